// File: rtl/u_lsu.sv
// rtl/u_lsu.sv - LSU data-memory responder: one request, WAIT wait states, byte-lane SRAM access
// Registered one-cycle response; lsu_busy stalls the initiator while a request is outstanding.
module u_lsu #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          WAIT  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic        lsu_busy,
  output logic        lsu_err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAITS, RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [3:0]    we_q, re_q;
  logic [31:0]   wd_q;
  logic          err_q;

  logic          req, accept, enter_resp, use_in;
  logic [31:0]   off;
  logic [AW-1:0] idx_in, idx_e;
  logic          err_in, err_e;
  logic [3:0]    we_e, re_e;
  logic [31:0]   wd_e, mask_w, mask_r;

  logic [31:0]   mem [DEPTH];

  function automatic logic legal_pat(input logic [3:0] p);
    case (p)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: legal_pat = 1'b1;
      default:                   legal_pat = 1'b0;
    endcase
  endfunction

  // Offset wraps below BASE, so a single high-bits test covers both range bounds.
  always_comb begin
    req    = (|lsu_we) | (|lsu_re);
    off    = lsu_a - BASE;
    idx_in = off[AW+1:2];
    err_in = ((off >> (AW + 2)) != 32'd0) | ((|lsu_we) & (|lsu_re)) | !legal_pat(lsu_we | lsu_re);
  end

  always_comb begin
    state_nxt = state;
    lsu_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          lsu_busy  = 1'b1;
          state_nxt = (WAIT > 0) ? WAITS : RESP;
        end
      end
      WAITS: begin
        lsu_busy = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With WAIT==0 the access happens on the accept edge, so bypass the capture registers.
  always_comb begin
    accept     = (state == IDLE) && req;
    enter_resp = (state_nxt == RESP) && (state != RESP);
    use_in     = (state == IDLE);
    idx_e      = use_in ? idx_in : idx_q;
    we_e       = use_in ? lsu_we : we_q;
    re_e       = use_in ? lsu_re : re_q;
    wd_e       = use_in ? lsu_wd : wd_q;
    err_e      = use_in ? err_in : err_q;
    mask_w     = '0;
    mask_r     = '0;
    for (int i = 0; i < 4; i++) begin
      mask_w[8*i +: 8] = {8{we_e[i]}};
      mask_r[8*i +: 8] = {8{re_e[i]}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      we_q    <= 4'd0;
      re_q    <= 4'd0;
      wd_q    <= 32'd0;
      err_q   <= 1'b0;
      lsu_vld <= 1'b0;
      lsu_rd  <= 32'd0;
      lsu_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q <= idx_in;
        we_q  <= lsu_we;
        re_q  <= lsu_re;
        wd_q  <= lsu_wd;
        err_q <= err_in;
        cnt   <= (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
      end else if ((state == WAITS) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      lsu_vld <= enter_resp;
      lsu_err <= enter_resp & err_e;
      lsu_rd  <= (enter_resp && !err_e && (we_e == 4'd0)) ? (mem[idx_e] & mask_r) : 32'd0;
    end
  end

  // Gated by rstn so a request held during reset cannot commit a write.
  always_ff @(posedge clk) begin
    if (rstn && enter_resp && !err_e && (we_e != 4'd0))
      mem[idx_e] <= (mem[idx_e] & ~mask_w) | (wd_e & mask_w);
  end
endmodule
